// File: rtl/seg7_snoop.sv
// ---------------------------------------------------------------------------
// seg7_snoop
//
// Passive snooper for a multiplexed, active-low, 4-digit seven-segment
// display bus. It watches the digit enables and the segment lines. Once a
// digit's pattern has been steady long enough, it decodes the pattern back
// into a hex nibble. When all four digits have been collected, it publishes
// the complete frame.
//
// Parameters
//   STABLE_CYCLES : consecutive identical samples needed to accept a digit
//                   (2..255)
//   FRAME_TIMEOUT : cycles allowed from the first accepted digit of a frame
//                   to frame completion
//
// Ports
//   clk         in   1   sole clock, rising edge
//   reset       in   1   synchronous, active-high reset
//   an          in   4   digit enables, active-low (an[i]=0 selects digit i)
//   sseg        in   7   segment lines, active-low, sseg[6]=a .. sseg[0]=g
//   value       out  16  last completed frame, digit i in value[4i+3:4i]
//   digit_err   out  4   bit i set if digit i of that frame was undecodable
//   frame_valid out  1   one-cycle pulse when value/digit_err update
//   timeout     out  1   one-cycle pulse when a partial frame is dropped
// ---------------------------------------------------------------------------
module seg7_snoop #(
  parameter int STABLE_CYCLES = 4,
  parameter int FRAME_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  sseg,
  output logic [15:0] value,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        timeout
);

  localparam int TO_W = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(FRAME_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE     = TO_W'(1);
  localparam logic [7:0]      STABLE_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0]      STABLE_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [10:0]     IDLE_SAMPLE = {4'b1111, 7'b1111111};

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // Bus sampling and stability tracking state
  logic [10:0]     sample_q, sample_d;
  logic [10:0]     prevSample_q, prevSample_d;
  logic [7:0]      stableCnt_q, stableCnt_d;

  // Frame assembly state
  state_t          state_q, state_d;
  logic [3:0]      seen_q, seen_d;
  logic [15:0]     shadowVal_q, shadowVal_d;
  logic [3:0]      shadowErr_q, shadowErr_d;
  logic [TO_W-1:0] toCnt_q, toCnt_d;
  logic [15:0]     value_q, value_d;
  logic [3:0]      digitErr_q, digitErr_d;
  logic            frameValid_q, frameValid_d;
  logic            timeout_q, timeout_d;

  // Decode results for the current stable sample
  logic            samplesEqual;
  logic            anValid;
  logic [1:0]      digitIdx;
  logic [3:0]      digitMask;
  logic [3:0]      nibble;
  logic            nibbleErr;
  logic            accept;
  logic            toExpire;
  logic [15:0]     mergedVal;
  logic [3:0]      mergedErr;
  logic [3:0]      mergedSeen;

  // Maps an active-low segment pattern back to its hex digit. The upper bit
  // of the result flags a pattern that is not one of the sixteen glyphs; such
  // a pattern reads as zero.
  function automatic logic [4:0] decodeSeg(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'b0000001: res = {1'b0, 4'h0};
      7'b1001111: res = {1'b0, 4'h1};
      7'b0010010: res = {1'b0, 4'h2};
      7'b0000110: res = {1'b0, 4'h3};
      7'b1001100: res = {1'b0, 4'h4};
      7'b0100100: res = {1'b0, 4'h5};
      7'b0100000: res = {1'b0, 4'h6};
      7'b0001111: res = {1'b0, 4'h7};
      7'b0000000: res = {1'b0, 4'h8};
      7'b0000100: res = {1'b0, 4'h9};
      7'b0001000: res = {1'b0, 4'hA};
      7'b1100000: res = {1'b0, 4'hB};
      7'b0110001: res = {1'b0, 4'hC};
      7'b1000010: res = {1'b0, 4'hD};
      7'b0110000: res = {1'b0, 4'hE};
      7'b0111000: res = {1'b0, 4'hF};
      default:    res = {1'b1, 4'h0};
    endcase
    return res;
  endfunction

  // The comparison uses the registered sample against the one before it,
  // not the raw input. This keeps the acceptance edge exactly STABLE_CYCLES
  // edges after the sampling edge. The counter restarts at 1 on any change
  // and parks at STABLE_CYCLES, so a held pattern is accepted only once.
  always_comb begin
    sample_d     = {an, sseg};
    prevSample_d = sample_q;
    samplesEqual = (sample_q == prevSample_q);
    if (!samplesEqual) begin
      stableCnt_d = 8'd1;
    end else if (stableCnt_q == STABLE_MAX) begin
      stableCnt_d = stableCnt_q;
    end else begin
      stableCnt_d = stableCnt_q + 8'd1;
    end
  end

  // Only a single selected digit is meaningful. Blanking (all enables high)
  // and ghosting with several enables low are both treated as "no digit".
  always_comb begin
    anValid   = 1'b1;
    digitIdx  = 2'd0;
    digitMask = 4'b0000;
    case (sample_q[10:7])
      4'b1110: begin digitIdx = 2'd0; digitMask = 4'b0001; end
      4'b1101: begin digitIdx = 2'd1; digitMask = 4'b0010; end
      4'b1011: begin digitIdx = 2'd2; digitMask = 4'b0100; end
      4'b0111: begin digitIdx = 2'd3; digitMask = 4'b1000; end
      default: anValid = 1'b0;
    endcase
    {nibbleErr, nibble} = decodeSeg(sample_q[6:0]);
    accept = samplesEqual && (stableCnt_q == STABLE_LAST) && anValid;
  end

  // The shadow copy is written with the newly accepted digit first. On a
  // completing acceptance, the published frame then includes that digit on
  // the same edge. A repeated digit simply overwrites its earlier value.
  always_comb begin
    mergedVal  = shadowVal_q;
    mergedErr  = shadowErr_q;
    mergedVal[{digitIdx, 2'b00} +: 4] = nibble;
    mergedErr[digitIdx]               = nibbleErr;
    mergedSeen = seen_q | digitMask;
  end

  // Frame state machine next-state logic. An expiring frame takes priority
  // over a coincident acceptance. That digit is not lost: it becomes the
  // first digit of a fresh frame with a freshly cleared timeout count.
  always_comb begin
    state_d      = state_q;
    seen_d       = seen_q;
    shadowVal_d  = shadowVal_q;
    shadowErr_d  = shadowErr_q;
    toCnt_d      = toCnt_q;
    value_d      = value_q;
    digitErr_d   = digitErr_q;
    frameValid_d = 1'b0;
    timeout_d    = 1'b0;
    toExpire     = (state_q == COLLECT) && (toCnt_q == TO_LAST);

    if (state_q == COLLECT) begin
      toCnt_d = toCnt_q + TO_ONE;
    end

    if (toExpire) begin
      timeout_d = 1'b1;
      seen_d    = 4'b0000;
      state_d   = IDLE;
      toCnt_d   = '0;
      if (accept) begin
        shadowVal_d = mergedVal;
        shadowErr_d = mergedErr;
        seen_d      = digitMask;
        state_d     = COLLECT;
      end
    end else if (accept) begin
      shadowVal_d = mergedVal;
      shadowErr_d = mergedErr;
      if (mergedSeen == 4'b1111) begin
        value_d      = mergedVal;
        digitErr_d   = mergedErr;
        frameValid_d = 1'b1;
        seen_d       = 4'b0000;
        state_d      = IDLE;
        toCnt_d      = '0;
      end else begin
        seen_d  = mergedSeen;
        state_d = COLLECT;
        if (state_q == IDLE) begin
          toCnt_d = '0;
        end
      end
    end
  end

  // All state lives here. Reset returns the sampler to the idle bus pattern,
  // so the first real digit after reset is seen as a change. Any partial
  // frame is discarded without a pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q     <= IDLE_SAMPLE;
      prevSample_q <= IDLE_SAMPLE;
      stableCnt_q  <= 8'd0;
      state_q      <= IDLE;
      seen_q       <= 4'b0000;
      shadowVal_q  <= 16'h0000;
      shadowErr_q  <= 4'b0000;
      toCnt_q      <= '0;
      value_q      <= 16'h0000;
      digitErr_q   <= 4'b0000;
      frameValid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      sample_q     <= sample_d;
      prevSample_q <= prevSample_d;
      stableCnt_q  <= stableCnt_d;
      state_q      <= state_d;
      seen_q       <= seen_d;
      shadowVal_q  <= shadowVal_d;
      shadowErr_q  <= shadowErr_d;
      toCnt_q      <= toCnt_d;
      value_q      <= value_d;
      digitErr_q   <= digitErr_d;
      frameValid_q <= frameValid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign value       = value_q;
  assign digit_err   = digitErr_q;
  assign frame_valid = frameValid_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_seg7_snoop.sv
// ---------------------------------------------------------------------------
// tb_seg7_snoop
//
// Directed bench for seg7_snoop. It uses STABLE_CYCLES=4 and
// FRAME_TIMEOUT=20. Inputs change on the falling edge, and outputs are
// sampled on the falling edge, away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_seg7_snoop;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  an;
  logic [6:0]  sseg;
  logic [15:0] value;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        timeout;

  int total   = 0;
  int bad     = 0;
  int fvCount = 0;
  int toCount = 0;

  seg7_snoop #(
    .STABLE_CYCLES(4),
    .FRAME_TIMEOUT(20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .an         (an),
    .sseg       (sseg),
    .value      (value),
    .digit_err  (digit_err),
    .frame_valid(frame_valid),
    .timeout    (timeout)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // Counts every cycle in which a pulse output is high. A pulse that is
  // stuck high or repeated shows up as an inflated count.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) fvCount++;
    if (timeout === 1'b1) toCount++;
  end

  // Drives one bus pattern for n rising edges. It is entered and left just
  // after a falling edge.
  task automatic applyStimulus(input logic [3:0] a, input logic [6:0] s, input int n);
    an   = a;
    sseg = s;
    repeat (n) @(negedge clk);
  endtask

  // Reset holds every output at zero, even with a valid digit on the bus
  task automatic test_reset;
    reset = 1'b1;
    an    = 4'b1110;
    sseg  = 7'b0000001;
    repeat (8) @(negedge clk);
    total++; if (value !== 16'h0000) begin bad++; $display("[TB] FAIL reset_value got=%h want=%h", value, 16'h0000); end
    total++; if (digit_err !== 4'b0000) begin bad++; $display("[TB] FAIL reset_err got=%b want=%b", digit_err, 4'b0000); end
    total++; if (frame_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_fv got=%b want=0", frame_valid); end
    total++; if (timeout !== 1'b0) begin bad++; $display("[TB] FAIL reset_to got=%b want=0", timeout); end
    an   = 4'b1111;
    sseg = 7'b1111111;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Sends 4,3,2,1 on digits 0..3, each held exactly four cycles, and checks
  // the exact cycle of the single frame_valid pulse
  task automatic test_basic_frame;
    int fv0, to0;
    fv0 = fvCount;
    to0 = toCount;
    applyStimulus(4'b1110, 7'b1001100, 4);
    applyStimulus(4'b1101, 7'b0000110, 4);
    applyStimulus(4'b1011, 7'b0010010, 4);
    applyStimulus(4'b0111, 7'b1001111, 4);
    total++; if (frame_valid !== 1'b0) begin bad++; $display("[TB] FAIL frame_fv_early got=%b want=0", frame_valid); end
    applyStimulus(4'b1111, 7'b1111111, 1);
    total++; if (frame_valid !== 1'b1) begin bad++; $display("[TB] FAIL frame_fv_edge got=%b want=1", frame_valid); end
    total++; if (value !== 16'h1234) begin bad++; $display("[TB] FAIL frame_value got=%h want=%h", value, 16'h1234); end
    total++; if (digit_err !== 4'b0000) begin bad++; $display("[TB] FAIL frame_err got=%b want=%b", digit_err, 4'b0000); end
    applyStimulus(4'b1111, 7'b1111111, 1);
    total++; if (frame_valid !== 1'b0) begin bad++; $display("[TB] FAIL frame_fv_late got=%b want=0", frame_valid); end
    applyStimulus(4'b1111, 7'b1111111, 6);
    total++; if (fvCount - fv0 !== 1) begin bad++; $display("[TB] FAIL frame_fv_count got=%0d want=1", fvCount - fv0); end
    total++; if (toCount - to0 !== 0) begin bad++; $display("[TB] FAIL frame_to_count got=%0d want=0", toCount - to0); end
    total++; if (value !== 16'h1234) begin bad++; $display("[TB] FAIL frame_value_hold got=%h want=%h", value, 16'h1234); end
  endtask

  // A digit held one cycle too short must not be accepted. If it were, a
  // frame would start, and a timeout would fire within the idle window.
  task automatic test_short_hold;
    int fv0, to0;
    fv0 = fvCount;
    to0 = toCount;
    applyStimulus(4'b1110, 7'b0001000, 3);
    applyStimulus(4'b1111, 7'b1111111, 30);
    total++; if (fvCount - fv0 !== 0) begin bad++; $display("[TB] FAIL short_fv_count got=%0d want=0", fvCount - fv0); end
    total++; if (toCount - to0 !== 0) begin bad++; $display("[TB] FAIL short_to_count got=%0d want=0", toCount - to0); end
    total++; if (value !== 16'h1234) begin bad++; $display("[TB] FAIL short_value got=%h want=%h", value, 16'h1234); end
  endtask

  // Ghost and blank enables are ignored. Three digits then expire exactly 20
  // cycles after the first acceptance, and the published frame is untouched.
  task automatic test_timeout;
    int fv0, to0;
    fv0 = fvCount;
    to0 = toCount;
    applyStimulus(4'b1100, 7'b0000001, 10);
    applyStimulus(4'b1111, 7'b1001111, 10);
    applyStimulus(4'b1110, 7'b0000100, 4);
    applyStimulus(4'b1101, 7'b0001000, 4);
    applyStimulus(4'b1011, 7'b1100000, 4);
    applyStimulus(4'b1111, 7'b1111111, 12);
    total++; if (timeout !== 1'b0) begin bad++; $display("[TB] FAIL to_early got=%b want=0", timeout); end
    applyStimulus(4'b1111, 7'b1111111, 1);
    total++; if (timeout !== 1'b1) begin bad++; $display("[TB] FAIL to_edge got=%b want=1", timeout); end
    applyStimulus(4'b1111, 7'b1111111, 1);
    total++; if (timeout !== 1'b0) begin bad++; $display("[TB] FAIL to_late got=%b want=0", timeout); end
    applyStimulus(4'b1111, 7'b1111111, 25);
    total++; if (toCount - to0 !== 1) begin bad++; $display("[TB] FAIL to_count got=%0d want=1", toCount - to0); end
    total++; if (fvCount - fv0 !== 0) begin bad++; $display("[TB] FAIL to_fv_count got=%0d want=0", fvCount - fv0); end
    total++; if (value !== 16'h1234) begin bad++; $display("[TB] FAIL to_value got=%h want=%h", value, 16'h1234); end
    total++; if (digit_err !== 4'b0000) begin bad++; $display("[TB] FAIL to_err got=%b want=%b", digit_err, 4'b0000); end
  endtask

  // A blank pattern on digit 2 decodes as zero with its error bit set
  task automatic test_error_frame;
    int fv0;
    fv0 = fvCount;
    applyStimulus(4'b1110, 7'b0000001, 4);
    applyStimulus(4'b1101, 7'b0000001, 4);
    applyStimulus(4'b1011, 7'b1111111, 4);
    applyStimulus(4'b0111, 7'b0000001, 4);
    applyStimulus(4'b1111, 7'b1111111, 6);
    total++; if (value !== 16'h0000) begin bad++; $display("[TB] FAIL err_value got=%h want=%h", value, 16'h0000); end
    total++; if (digit_err !== 4'b0100) begin bad++; $display("[TB] FAIL err_bits got=%b want=%b", digit_err, 4'b0100); end
    total++; if (fvCount - fv0 !== 1) begin bad++; $display("[TB] FAIL err_fv_count got=%0d want=1", fvCount - fv0); end
  endtask

  // A reset mid-frame must drop the three collected digits. Digit 3 is sent
  // first afterwards, so a leftover seen mask would complete a frame early.
  task automatic test_reset_mid_frame;
    int fv0, to0;
    fv0 = fvCount;
    to0 = toCount;
    applyStimulus(4'b1110, 7'b1001111, 4);
    applyStimulus(4'b1101, 7'b0010010, 4);
    applyStimulus(4'b1011, 7'b0000110, 4);
    applyStimulus(4'b1111, 7'b1111111, 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (value !== 16'h0000) begin bad++; $display("[TB] FAIL rst_mid_value got=%h want=%h", value, 16'h0000); end
    total++; if (digit_err !== 4'b0000) begin bad++; $display("[TB] FAIL rst_mid_err got=%b want=%b", digit_err, 4'b0000); end
    applyStimulus(4'b0111, 7'b0000000, 4);
    applyStimulus(4'b1110, 7'b0100100, 4);
    applyStimulus(4'b1101, 7'b0100000, 4);
    applyStimulus(4'b1011, 7'b0001111, 4);
    applyStimulus(4'b1111, 7'b1111111, 25);
    total++; if (value !== 16'h8765) begin bad++; $display("[TB] FAIL rst_frame_value got=%h want=%h", value, 16'h8765); end
    total++; if (digit_err !== 4'b0000) begin bad++; $display("[TB] FAIL rst_frame_err got=%b want=%b", digit_err, 4'b0000); end
    total++; if (fvCount - fv0 !== 1) begin bad++; $display("[TB] FAIL rst_fv_count got=%0d want=1", fvCount - fv0); end
    total++; if (toCount - to0 !== 0) begin bad++; $display("[TB] FAIL rst_to_count got=%0d want=0", toCount - to0); end
  endtask

  // Runs the scenarios in order. Each scenario leaves the bus idle and the
  // snooper between frames.
  initial begin
    reset = 1'b1;
    an    = 4'b1111;
    sseg  = 7'b1111111;
    test_reset();
    test_basic_frame();
    test_short_hold();
    test_timeout();
    test_error_frame();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guards against a stalled run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=expired want=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/seg7_snoop.md
SEG7_SNOOP -- requirements
Module: seg7_snoop

Interface
- REQ-001: Parameter STABLE_CYCLES, default 4; number of consecutive identical samples required to accept a digit (legal range 2..255).
- REQ-002: Parameter FRAME_TIMEOUT, default 65535; maximum cycles from the first accepted digit of a frame to frame completion.
- REQ-003: clk  input  1  sole clock; all state updates on the rising edge.
- REQ-004: reset  input  1  synchronous, active-high reset.
- REQ-005: an  input  4  digit enables, active-low; an[i]=0 selects digit i.
- REQ-006: sseg  input  7  segment lines, active-low; sseg[6]=a down to sseg[0]=g.
- REQ-007: value  output  16  last completed frame; digit i in value[4i+3:4i].
- REQ-008: digit_err  output  4  bit i is 1 if digit i of the last frame held an unknown pattern.
- REQ-009: frame_valid  output  1  one-cycle pulse when value and digit_err update.
- REQ-010: timeout  output  1  one-cycle pulse when a partial frame is discarded.

Function
- REQ-011: The block SHALL register {an,sseg} every cycle into a sample register and SHALL compare each new sample with the previous one.
- REQ-012: Stability counter: reset to 1 on any difference; increment on equality, saturating at STABLE_CYCLES.
- REQ-013: A digit is accepted exactly once, on the edge where the counter reaches STABLE_CYCLES; no re-acceptance until the sample changes.
- REQ-014: Acceptance is suppressed unless an has exactly one bit low; an=4'b1111 (blanking) and multi-low values are ignored.
- REQ-015: Pattern-to-nibble map (sseg -> nibble): 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 0001000->A, 1100000->B, 0110001->C, 1000010->D, 0110000->E, 0111000->F.
- REQ-016: Any other pattern SHALL yield nibble 0 with the error bit set for that digit.
- REQ-017: On acceptance, the shadow nibble, shadow error bit, and seen-mask bit for the selected digit are written; re-acceptance of an already-seen digit overwrites its shadow value (latest wins).
- REQ-018: FSM states are IDLE (seen mask 0) and COLLECT (seen mask nonzero); the first acceptance moves IDLE to COLLECT and clears the timeout counter.
- REQ-019: When an acceptance makes the seen mask 4'b1111, then on that same edge value and digit_err load the shadow contents including the new digit, the seen mask clears, and the FSM returns to IDLE; frame_valid is high for the following cycle only.
- REQ-020: In COLLECT, the timeout counter increments each cycle; reaching FRAME_TIMEOUT without completion SHALL clear the seen mask, return to IDLE, and pulse timeout for one cycle, leaving value and digit_err unchanged.
- REQ-021: When an acceptance coincides with the timeout edge, the timeout wins, and the accepted digit starts a new frame in COLLECT.
- REQ-022: value and digit_err SHALL hold between frames.
- REQ-023: Latency: with inputs changed before edge k and held, acceptance occurs at edge k+STABLE_CYCLES, where edge k is the sampling edge.

Reset
- REQ-024: While reset is high at an edge, the block SHALL set value=16'h0000, digit_err=4'b0000, frame_valid=0, timeout=0, FSM=IDLE, seen mask=0, shadows=0, stability counter=0, and the sample register to an=4'b1111, sseg=7'b1111111.
- REQ-025: Reset asserted mid-frame SHALL discard the partial frame and emit no frame_valid or timeout pulse.

Verification
- REQ-026: Drive an=1110/sseg=1001100, an=1101/0000110, an=1011/0010010, an=0111/1001111, each held 4 cycles -> value=16'h1234, digit_err=0000, exactly one frame_valid pulse.
- REQ-027: Hold an=1110/sseg=0001000 for 3 cycles, then change -> no acceptance; seen mask remains 0 and no outputs change.
- REQ-028: Full frame with digit 2 driven as sseg=1111111 and the other digits as 0 -> value=16'h0000, digit_err=0100, frame_valid pulses.
- REQ-029: Drive an=1100 or an=1111 for 10 cycles -> ignored; accept digits 0 to 2 only, with FRAME_TIMEOUT=20 -> timeout pulses once 20 cycles after the first acceptance; value is unchanged and there is no frame_valid.
- REQ-030: Accept digits 0 to 2, assert reset for 1 cycle, then send a full frame of 5,6,7,8 -> value=16'h8765 with a single frame_valid and no stale digits.
